// File: rtl/hdmi_fetch_pkg.sv
// hdmi_fetch_pkg: shared types, default sizing constants and the burst-length
// helper for the HDMI framebuffer fetch scheduler.
package hdmi_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_ISSUE      = 2'd2,
    ST_DRAIN      = 2'd3
  } fetch_state_t;

  // Default configuration: 512-bit AXI data path.
  localparam int BPB                 = 64;
  localparam int BOUNDARY_4K         = 4096;
  localparam int DEF_BUF_BEATS       = 256;
  localparam int DEF_MAX_OUTSTANDING = 4;
  localparam int CREDIT_W_DEF        = $clog2(DEF_BUF_BEATS + 1);
  localparam int OUTST_W_DEF         = $clog2(DEF_MAX_OUTSTANDING + 1);

  // Burst length = min(max burst, beats left in the line, beats to the next 4KB page).
  // The address is beat aligned, so the page term is always at least 1.
  function automatic logic [8:0] calc_burst_len(
    input logic [8:0]  max_burst,
    input logic [11:0] beats_left,
    input logic [11:0] addr_lo,
    input int unsigned bpb_log2
  );
    logic [12:0] to_4k;
    logic [12:0] lim;
    logic [12:0] len;
    to_4k = (13'(BOUNDARY_4K) - {1'b0, addr_lo}) >> bpb_log2;
    lim   = ({4'd0, max_burst} < {1'b0, beats_left}) ? {4'd0, max_burst} : {1'b0, beats_left};
    len   = (to_4k < lim) ? to_4k : lim;
    return 9'(len);
  endfunction

endpackage

// File: rtl/hdmi_fetch_scheduler_if.sv
// hdmi_fetch_scheduler_if: AXI4 read-address channel carried between the
// fetch scheduler (master) and the interconnect (slave).
interface hdmi_fetch_scheduler_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 2
) ();

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic              arvalid;
  logic              arready;

  modport master (
    output arid,
    output araddr,
    output arlen,
    output arvalid,
    input  arready
  );

  modport slave (
    input  arid,
    input  araddr,
    input  arlen,
    input  arvalid,
    output arready
  );

endinterface

// File: rtl/hdmi_fetch_credit.sv
// hdmi_fetch_credit: line-buffer credit pool (saturating) and outstanding-burst
// counter. can_issue says whether a burst of req_len beats may be requested now.
module hdmi_fetch_credit
  import hdmi_fetch_pkg::*;
#(
  parameter int C_BUF_BEATS       = DEF_BUF_BEATS,
  parameter int C_MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int CREDIT_W          = CREDIT_W_DEF,
  parameter int OUTST_W           = OUTST_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue,
  input  logic [8:0] issue_len,
  input  logic [8:0] req_len,
  input  logic       beat_freed,
  input  logic       r_done,
  output logic       can_issue,
  output logic       drained
);

  localparam logic [15:0] MAX_CREDIT = 16'(C_BUF_BEATS);
  localparam logic [15:0] MAX_OUTST  = 16'(C_MAX_OUTSTANDING);

  logic [CREDIT_W-1:0] credit_r;
  logic [OUTST_W-1:0]  outst_r;
  logic [15:0]         credit_sum;
  logic [15:0]         credit_next;
  logic [OUTST_W-1:0]  outst_next;

  // Net the issue deduction and the freed beat, then clamp at the pool size.
  always_comb begin
    credit_sum = 16'(credit_r) - (issue ? 16'(issue_len) : 16'd0)
               + (beat_freed ? 16'd1 : 16'd0);
    if (credit_sum > MAX_CREDIT) begin
      credit_next = MAX_CREDIT;
    end else begin
      credit_next = credit_sum;
    end
  end

  // Outstanding bursts: +1 on issue, -1 on RLAST (floored), unchanged when both.
  always_comb begin
    outst_next = outst_r;
    case ({issue, r_done})
      2'b10:   outst_next = outst_r + OUTST_W'(1);
      2'b01:   outst_next = (outst_r == '0) ? outst_r : outst_r - OUTST_W'(1);
      default: outst_next = outst_r;
    endcase
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_r <= CREDIT_W'(C_BUF_BEATS);
      outst_r  <= '0;
    end else begin
      credit_r <= CREDIT_W'(credit_next);
      outst_r  <= outst_next;
    end
  end

  assign can_issue = (16'(credit_r) >= 16'(req_len)) && (16'(outst_r) < MAX_OUTST);
  assign drained   = (outst_r == '0);

endmodule

// File: rtl/hdmi_fetch_scheduler.sv
// hdmi_fetch_scheduler: issues 4KB-safe AXI4 read bursts covering one frame per
// frame_start, throttled by line-buffer credit and outstanding-burst limit.
// Optional macro HDMI_FETCH_PERF_EN enables the perf_stall cycle counter;
// without it perf_stall is constant zero.
module hdmi_fetch_scheduler
  import hdmi_fetch_pkg::*;
#(
  parameter int C_ADDR_WIDTH      = 32,
  parameter int C_ID_WIDTH        = 2,
  parameter int C_DATA_WIDTH      = BPB * 8,
  parameter int C_ARID            = 0,
  parameter int C_MAX_BURST       = 16,
  parameter int C_BUF_BEATS       = DEF_BUF_BEATS,
  parameter int C_MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_en,
  input  logic [C_ADDR_WIDTH-1:0] cfg_base,
  input  logic [15:0]             cfg_stride,
  input  logic [11:0]             cfg_line_beats,
  input  logic [11:0]             cfg_lines,
  input  logic                    frame_start,
  input  logic                    beat_freed,
  input  logic                    r_done,
  hdmi_fetch_scheduler_if.master  m_ar,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun,
  output logic [31:0]             perf_stall
);

  localparam int BPB_LOG2 = $clog2(C_DATA_WIDTH / 8);

  fetch_state_t            state_r;
  fetch_state_t            state_next;
  logic [C_ADDR_WIDTH-1:0] line_addr_r;
  logic [11:0]             beat_ptr_r;
  logic [11:0]             line_r;
  logic [15:0]             lat_stride_r;
  logic [11:0]             lat_line_beats_r;
  logic [11:0]             lat_lines_r;
  logic                    arvalid_r;
  logic [C_ADDR_WIDTH-1:0] araddr_r;
  logic [7:0]              arlen_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    overrun_r;

  logic [11:0]             beats_left_s;
  logic [C_ADDR_WIDTH-1:0] cur_addr_s;
  logic [8:0]              burst_len_s;
  logic [8:0]              issue_len_s;
  logic                    hs_s;
  logic                    line_end_s;
  logic                    last_line_s;
  logic                    can_issue_s;
  logic                    drained_s;
  logic                    load_frame_s;
  logic                    start_ar_s;
  logic                    drain_done_s;

  assign beats_left_s = lat_line_beats_r - beat_ptr_r;
  assign cur_addr_s   = line_addr_r + (C_ADDR_WIDTH'(beat_ptr_r) << BPB_LOG2);
  assign burst_len_s  = calc_burst_len(9'(C_MAX_BURST), beats_left_s, cur_addr_s[11:0], BPB_LOG2);
  assign issue_len_s  = {1'b0, arlen_r} + 9'd1;
  assign hs_s         = arvalid_r & m_ar.arready;
  assign line_end_s   = (beat_ptr_r + 12'(issue_len_s)) == lat_line_beats_r;
  assign last_line_s  = (line_r + 12'd1) == lat_lines_r;

  hdmi_fetch_credit #(
    .C_BUF_BEATS      (C_BUF_BEATS),
    .C_MAX_OUTSTANDING(C_MAX_OUTSTANDING),
    .CREDIT_W         ($clog2(C_BUF_BEATS + 1)),
    .OUTST_W          ($clog2(C_MAX_OUTSTANDING + 1))
  ) u_credit (
    .clk       (clk),
    .rst       (rst),
    .issue     (hs_s),
    .issue_len (issue_len_s),
    .req_len   (burst_len_s),
    .beat_freed(beat_freed),
    .r_done    (r_done),
    .can_issue (can_issue_s),
    .drained   (drained_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_next   = state_r;
    load_frame_s = 1'b0;
    start_ar_s   = 1'b0;
    drain_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cfg_en) begin
          state_next = ST_WAIT_FRAME;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT_FRAME: begin
        if (!cfg_en) begin
          state_next = ST_IDLE;
        end else if (frame_start) begin
          load_frame_s = 1'b1;
          // An empty frame skips straight to completion without any AR.
          if ((cfg_line_beats == 12'd0) || (cfg_lines == 12'd0)) begin
            state_next = ST_DRAIN;
          end else begin
            state_next = ST_ISSUE;
          end
        end else begin
          state_next = ST_WAIT_FRAME;
        end
      end
      ST_ISSUE: begin
        if (arvalid_r) begin
          // A presented request is never withdrawn; leave only after its handshake.
          if (hs_s && (!cfg_en || (line_end_s && last_line_s))) begin
            state_next = ST_DRAIN;
          end else begin
            state_next = ST_ISSUE;
          end
        end else if (!cfg_en) begin
          state_next = ST_DRAIN;
        end else if (can_issue_s) begin
          start_ar_s = 1'b1;
        end else begin
          state_next = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (drained_s) begin
          drain_done_s = 1'b1;
          state_next   = cfg_en ? ST_WAIT_FRAME : ST_IDLE;
        end else begin
          state_next = ST_DRAIN;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Frame latch, address walk and registered AR channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_addr_r      <= '0;
      beat_ptr_r       <= 12'd0;
      line_r           <= 12'd0;
      lat_stride_r     <= 16'd0;
      lat_line_beats_r <= 12'd0;
      lat_lines_r      <= 12'd0;
      arvalid_r        <= 1'b0;
      araddr_r         <= '0;
      arlen_r          <= 8'd0;
    end else begin
      if (load_frame_s) begin
        line_addr_r      <= cfg_base;
        beat_ptr_r       <= 12'd0;
        line_r           <= 12'd0;
        lat_stride_r     <= cfg_stride;
        lat_line_beats_r <= cfg_line_beats;
        lat_lines_r      <= cfg_lines;
      end else if (hs_s) begin
        if (line_end_s) begin
          beat_ptr_r  <= 12'd0;
          line_addr_r <= line_addr_r + C_ADDR_WIDTH'(lat_stride_r);
          line_r      <= line_r + 12'd1;
        end else begin
          beat_ptr_r <= beat_ptr_r + 12'(issue_len_s);
        end
      end else begin
        beat_ptr_r <= beat_ptr_r;
      end
      if (start_ar_s) begin
        arvalid_r <= 1'b1;
        araddr_r  <= cur_addr_s;
        arlen_r   <= 8'(burst_len_s - 9'd1);
      end else if (hs_s) begin
        arvalid_r <= 1'b0;
      end else begin
        arvalid_r <= arvalid_r;
      end
    end
  end

  // Frame status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (load_frame_s) begin
        busy_r <= 1'b1;
      end else if (drain_done_s) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
      done_r <= drain_done_s;
      // A frame pulse during an active frame is dropped but remembered.
      if (frame_start && busy_r) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

`ifdef HDMI_FETCH_PERF_EN
  logic [31:0] perf_r;
  logic        stall_s;

  assign stall_s = (arvalid_r & ~m_ar.arready) | (~arvalid_r & ~can_issue_s);

  // Stall cycles within ISSUE, restarted by each accepted frame, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_r <= 32'd0;
    end else if (load_frame_s) begin
      perf_r <= 32'd0;
    end else if ((state_r == ST_ISSUE) && stall_s && (perf_r != 32'hFFFF_FFFF)) begin
      perf_r <= perf_r + 32'd1;
    end else begin
      perf_r <= perf_r;
    end
  end

  assign perf_stall = perf_r;
`else
  assign perf_stall = 32'd0;
`endif

  assign m_ar.arid    = C_ID_WIDTH'(C_ARID);
  assign m_ar.araddr  = araddr_r;
  assign m_ar.arlen   = arlen_r;
  assign m_ar.arvalid = arvalid_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign overrun      = overrun_r;

endmodule

// File: doc/hdmi_fetch_scheduler.md
Name: hdmi_fetch_scheduler

Overview:
Schedules AXI4 read-address bursts that fetch the framebuffer for the HDMI scan-out path, one frame per FRAME_START pulse (derived from VSYNC).
Sits between the APB-programmed frame registers and the master AXI AR channel; the R channel feeds the pixel line buffer directly.
Limits issue by line-buffer credit and by the number of outstanding bursts.
Never crosses a 4KB boundary.

Parameters:
C_ADDR_WIDTH, 32, AR address width
C_ID_WIDTH, 2, ARID width
C_DATA_WIDTH, 512, AXI data width; BPB = C_DATA_WIDTH/8 bytes per beat (power of 2)
C_ARID, 0, constant ARID value
C_MAX_BURST, 16, max beats per burst (1..256)
C_BUF_BEATS, 256, line-buffer capacity in beats (credit pool)
C_MAX_OUTSTANDING, 4, max AR bursts without RLAST

Ports:
CLK  in  1  clock; reset is synchronous and active-high (RST)
RST  in  1  synchronous active-high reset
CFG_EN  in  1  scheduler enable
CFG_BASE  in  C_ADDR_WIDTH  frame base byte address, BPB-aligned
CFG_STRIDE  in  16  line pitch in bytes, BPB-aligned
CFG_LINE_BEATS  in  12  beats per line
CFG_LINES  in  12  lines per frame
FRAME_START  in  1  one-cycle frame-start pulse
BEAT_FREED  in  1  pixel side consumed one buffer beat
R_DONE  in  1  RVALID&RREADY&RLAST observed
M_ARID  out  C_ID_WIDTH  =C_ARID
M_ARADDR  out  C_ADDR_WIDTH  burst address
M_ARLEN  out  8  beats-1
M_ARVALID  out  1  request valid
M_ARREADY  in  1  slave ready
BUSY  out  1  frame in progress
DONE  out  1  one-cycle pulse at frame completion
OVERRUN  out  1  sticky: FRAME_START arrived while BUSY
PERF_STALL  out  32  see Optional Feature

Behaviour:
- Reset values:
  - M_ARVALID=0, M_ARADDR=0, M_ARLEN=0, BUSY=0, DONE=0, OVERRUN=0, PERF_STALL=0.
  - credit=C_BUF_BEATS, outstanding=0, state=IDLE.
- States: IDLE, WAIT_FRAME, ISSUE, DRAIN.
  - IDLE: CFG_EN=1 -> WAIT_FRAME.
  - WAIT_FRAME: CFG_EN=0 -> IDLE. FRAME_START -> latch CFG_*, line_addr=base, beat_ptr=0, line=0, BUSY=1 -> ISSUE.
  - If the latched LINE_BEATS or LINES is 0, go straight to DRAIN with no AR.
- ISSUE, burst length:
  - len = min(C_MAX_BURST, LINE_BEATS-beat_ptr, (4096-addr[11:0])/BPB).
  - addr = line_addr + beat_ptr*BPB.
- ISSUE, issue condition: assert M_ARVALID with ARADDR=addr, ARLEN=len-1 only when credit>=len and outstanding<C_MAX_OUTSTANDING.
- ISSUE, handshake: ARVALID/ARADDR/ARLEN hold stable until M_ARVALID&M_ARREADY, and ARVALID never drops without a handshake.
- ISSUE, on handshake:
  - credit -= len, outstanding += 1, beat_ptr += len.
  - If beat_ptr reaches LINE_BEATS: beat_ptr=0, line_addr += STRIDE, line += 1.
  - After the last line -> DRAIN.
- Back-to-back: the next AR may be valid in the cycle after a handshake (1 burst/2 cycles min; 1/cycle permitted).
- DRAIN: wait outstanding==0, then DONE=1 for one cycle, BUSY=0 -> WAIT_FRAME (or IDLE if CFG_EN=0).
- Credit:
  - BEAT_FREED adds 1, saturating at C_BUF_BEATS.
  - An issue and a free in the same cycle net both.
- Outstanding: R_DONE subtracts 1, floored at 0. An issue and R_DONE in the same cycle leaves it unchanged.
- FRAME_START while BUSY: set OVERRUN (sticky until RST), ignore the pulse, current frame continues.
- CFG_EN falls while BUSY: complete a pending AR handshake, issue no further bursts, -> DRAIN.
- CFG_* changes while BUSY: no effect (latched).
- Address arithmetic: modulo 2^C_ADDR_WIDTH (wrap, no error).
- RST mid-operation: all state returns to reset values next cycle. In-flight R beats are the system's concern.

Optional Feature:
Macro HDMI_FETCH_PERF_EN.
- Defined: PERF_STALL counts cycles in ISSUE with (M_ARVALID&!M_ARREADY) or a credit/outstanding block. It clears on FRAME_START accepted and saturates at 0xFFFFFFFF.
- Undefined: PERF_STALL is tied to 0 and no counter logic exists; the port list is unchanged.

Decomposition:
- Package hdmi_fetch_pkg:
  - state enum typedef fetch_state_t.
  - localparams BPB, BOUNDARY_4K=4096, credit width $clog2(C_BUF_BEATS+1), outstanding width.
  - a function computing burst length.
- One sub-module, hdmi_fetch_credit: the saturating credit counter plus the outstanding counter, with can_issue output.
- The FSM and address generation stay in the top.

Test Plan:
1. BASE=0x1000, STRIDE=0x400, LINE_BEATS=16, LINES=2, ARREADY=1, frees keep pace -> two ARs, 0x1000/LEN=15 and 0x1400/LEN=15; DONE after both R_DONE.
2. BASE=0x0F80, LINE_BEATS=16, LINES=1 -> 4KB split: AR 0x0F80/LEN=1, then 0x1000/LEN=13.
3. C_BUF_BEATS=32, LINE_BEATS=16, LINES=4, no BEAT_FREED -> exactly 2 ARs, then ARVALID stays 0. 16 BEAT_FREED pulses -> a third AR issues.
4. ARREADY held 0 for 10 cycles -> ARVALID/ARADDR/ARLEN stable throughout. With PERF_EN, PERF_STALL=10.
5. FRAME_START during ISSUE -> OVERRUN=1, frame completes, one DONE only. Then LINES=0 and FRAME_START -> DONE next cycle, no AR.
6. RST asserted mid-ISSUE with ARVALID=1 -> next cycle ARVALID=0, BUSY=0, credit=C_BUF_BEATS, state IDLE.
